// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised external interrupt controller driving cp0 ir_in.
// Build option IRQ_LEVEL_EN selects level-sensitive sources (default: edge).
module irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ack,
  output logic             ir_out,
  output logic [ID_W-1:0]  cause_id,
  output logic             busy,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [N_SRC-1:0] s1;
  logic [N_SRC-1:0] s2;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] grant;
  logic [ID_W-1:0]  win_id;
  logic             claim;

  // two-flop synchroniser on every raw line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= irq_src;
      s2 <= s1;
    end
  end

`ifdef IRQ_LEVEL_EN

  // level mode: pending simply mirrors the synchronised line
  always_comb begin
    pending = s2;
  end

`else

  logic [N_SRC-1:0] s3;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] pend_q;

  // history flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3 <= '0;
    end else begin
      s3 <= s2;
    end
  end

  // edge detect and claim-clear; a fresh edge beats the clear
  always_comb begin
    rise = s2 & ~s3;
    clr  = claim ? grant : '0;
  end

  // sticky pending bits, independent of the mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~clr) | rise;
    end
  end

  // expose the sticky register to software
  always_comb begin
    pending = pend_q;
  end

`endif

  // software mask, all sources disabled out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  // lowest enabled pending index wins
  always_comb begin
    req    = pending & mask;
    grant  = req & (~req + N_SRC'(1));
    claim  = (state == S_IDLE) && (|req);
    win_id = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        win_id = win_id | ID_W'(i);
      end
    end
  end

  // claim / pulse / service sequencing
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (claim) begin
          state_nx = S_REQ;
        end
      end
      (state == S_REQ): begin
        state_nx = S_SVC;
      end
      (state == S_SVC): begin
        if (ack) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // state register, abandoned immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // one-cycle request pulse to cp0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_out <= 1'b0;
    end else begin
      ir_out <= claim;
    end
  end

  // claimed id, held until the next claim
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_id <= '0;
    end else if (claim) begin
      cause_id <= win_id;
    end
  end

  // outstanding-interrupt flag
  always_comb begin
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: vector table plus id scoreboard for irq_ctrl.
// Level-mode vectors are selected when IRQ_LEVEL_EN is defined.
module tb_irq_ctrl;

  typedef struct {
    logic [7:0] irq;
    logic       mwe;
    logic [7:0] mwd;
    logic       ack;
    logic       e_ir;
    logic [2:0] e_id;
    logic       e_busy;
    logic [7:0] e_pend;
    logic [7:0] e_mask;
    int         push;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] irq_src;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ack;
  logic       ir_out;
  logic [2:0] cause_id;
  logic       busy;
  logic [7:0] pending;
  logic [7:0] mask;

  int         checks;
  int         errors;
  logic       prev_ir;
  logic [2:0] exp_q[$];
  vec_t       tbl[$];

  irq_ctrl #(.N_SRC(8), .ID_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .ack       (ack),
    .ir_out    (ir_out),
    .cause_id  (cause_id),
    .busy      (busy),
    .pending   (pending),
    .mask      (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [7:0] irq, input logic mwe,
    input logic [7:0] mwd, input logic ak,
    input logic eir, input logic [2:0] eid,
    input logic eb, input logic [7:0] ep,
    input logic [7:0] em, input int push);
    vec_t v;
    v.irq = irq; v.mwe = mwe; v.mwd = mwd;
    v.ack = ak; v.e_ir = eir; v.e_id = eid;
    v.e_busy = eb; v.e_pend = ep;
    v.e_mask = em; v.push = push;
    return v;
  endfunction

  task automatic chk(input string nm,
    input logic eir, input logic [2:0] eid,
    input logic eb, input logic [7:0] ep,
    input logic [7:0] em);
    checks++;
    if ({ir_out, cause_id, busy, pending, mask}
        !== {eir, eid, eb, ep, em}) begin
      errors++;
      $display("FAIL %s got ir=%b id=%0d busy=%b pend=%h mask=%h want ir=%b id=%0d busy=%b pend=%h mask=%h",
        nm, ir_out, cause_id, busy, pending, mask,
        eir, eid, eb, ep, em);
    end
  endtask

  // scoreboard: every ir_out pulse consumes one expected id
  always @(negedge clk) begin
    if (ir_out) begin
      logic [2:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL irq_unexpected got id=%0d want no pulse",
          cause_id);
      end else begin
        e = exp_q.pop_front();
        if (cause_id !== e || prev_ir) begin
          errors++;
          $display("FAIL irq_pulse got id=%0d back2back=%b want id=%0d back2back=0",
            cause_id, prev_ir, e);
        end
      end
    end
    prev_ir = ir_out;
  end

  initial begin
    bit done;
`ifdef IRQ_LEVEL_EN
    tbl.push_back(mk(8'h00,1,8'hFF,0, 0,0,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h01,0,8'h00,0, 0,0,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h01,0,8'h00,0, 0,0,0,8'h01,8'hFF, 0));
    tbl.push_back(mk(8'h01,0,8'h00,0, 1,0,1,8'h01,8'hFF,-1));
    tbl.push_back(mk(8'h01,0,8'h00,0, 0,0,1,8'h01,8'hFF,-1));
    tbl.push_back(mk(8'h01,0,8'h00,1, 0,0,0,8'h01,8'hFF, 0));
    tbl.push_back(mk(8'h01,0,8'h00,0, 1,0,1,8'h01,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,0,1,8'h01,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,0,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,0,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,0,0,8'h00,8'hFF,-1));
`else
    tbl.push_back(mk(8'h00,1,8'hFF,0, 0,0,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h20,0,8'h00,0, 0,0,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h20,0,8'h00,0, 0,0,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h20,0,8'h00,0, 0,0,0,8'h20,8'hFF, 5));
    tbl.push_back(mk(8'h20,0,8'h00,0, 1,5,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h20,0,8'h00,1, 0,5,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h20,0,8'h00,0, 0,5,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,5,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,5,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h44,0,8'h00,0, 0,5,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h44,0,8'h00,0, 0,5,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h44,0,8'h00,0, 0,5,0,8'h44,8'hFF, 2));
    tbl.push_back(mk(8'h44,0,8'h00,0, 1,2,1,8'h40,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,2,1,8'h40,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,2,0,8'h40,8'hFF, 6));
    tbl.push_back(mk(8'h00,0,8'h00,0, 1,6,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,6,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,6,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,1,8'h00,1, 0,6,0,8'h00,8'h00,-1));
    tbl.push_back(mk(8'h08,0,8'h00,0, 0,6,0,8'h00,8'h00,-1));
    tbl.push_back(mk(8'h08,0,8'h00,0, 0,6,0,8'h00,8'h00,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,6,0,8'h08,8'h00,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,6,0,8'h08,8'h00,-1));
    tbl.push_back(mk(8'h00,1,8'h08,0, 0,6,0,8'h08,8'h08, 3));
    tbl.push_back(mk(8'h00,0,8'h00,0, 1,3,1,8'h00,8'h08,-1));
    tbl.push_back(mk(8'h00,1,8'h00,0, 0,3,1,8'h00,8'h00,-1));
    tbl.push_back(mk(8'h00,1,8'hFF,0, 0,3,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,3,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h02,0,8'h00,0, 0,3,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h02,0,8'h00,0, 0,3,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h02,0,8'h00,0, 0,3,0,8'h02,8'hFF, 1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 1,1,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,1,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h02,0,8'h00,0, 0,1,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h02,0,8'h00,0, 0,1,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h02,0,8'h00,0, 0,1,1,8'h02,8'hFF, 1));
    tbl.push_back(mk(8'h02,0,8'h00,1, 0,1,0,8'h02,8'hFF,-1));
    tbl.push_back(mk(8'h02,0,8'h00,0, 1,1,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h02,0,8'h00,0, 0,1,1,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h02,0,8'h00,1, 0,1,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,1,0,8'h00,8'hFF,-1));
    tbl.push_back(mk(8'h00,1,8'h00,0, 0,1,0,8'h00,8'h00,-1));
    tbl.push_back(mk(8'h10,0,8'h00,0, 0,1,0,8'h00,8'h00,-1));
    tbl.push_back(mk(8'h10,0,8'h00,0, 0,1,0,8'h00,8'h00,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,1,0,8'h10,8'h00,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,1,0,8'h10,8'h00,-1));
    tbl.push_back(mk(8'h10,0,8'h00,0, 0,1,0,8'h10,8'h00,-1));
    tbl.push_back(mk(8'h10,1,8'h10,0, 0,1,0,8'h10,8'h10, 4));
    tbl.push_back(mk(8'h10,0,8'h00,0, 1,4,1,8'h10,8'h10, 4));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,4,1,8'h10,8'h10,-1));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,4,0,8'h10,8'h10,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 1,4,1,8'h00,8'h10,-1));
    tbl.push_back(mk(8'h00,0,8'h00,0, 0,4,1,8'h00,8'h10,-1));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,4,0,8'h00,8'h10,-1));
`endif
    checks = 0;
    errors = 0;
    prev_ir = 1'b0;
    rst = 1'b0;
    irq_src = '0;
    mask_we = 1'b0;
    mask_wdata = '0;
    ack = 1'b0;
    #1 rst = 1'b1;
    #2 chk("reset", 0, 0, 0, 8'h00, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      irq_src    = tbl[k].irq;
      mask_we    = tbl[k].mwe;
      mask_wdata = tbl[k].mwd;
      ack        = tbl[k].ack;
      if (tbl[k].push >= 0) exp_q.push_back(3'(tbl[k].push));
      @(posedge clk);
      #1 chk($sformatf("vec%0d", k), tbl[k].e_ir, tbl[k].e_id,
             tbl[k].e_busy, tbl[k].e_pend, tbl[k].e_mask);
    end

    irq_src = 8'h10;
    mask_we = 1'b1;
    mask_wdata = 8'h10;
    ack = 1'b0;
    exp_q.push_back(3'd4);
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      @(posedge clk);
      #1 mask_we = 1'b0;
      if (busy && !ir_out) done = 1'b1;
    end
    checks++;
    if (!(busy === 1'b1 && cause_id === 3'd4 && ir_out === 1'b0)) begin
      errors++;
      $display("FAIL svc_before_reset got busy=%b id=%0d want busy=1 id=4",
        busy, cause_id);
    end
    #3 rst = 1'b1;
    irq_src = '0;
    #1 chk("async_reset", 0, 0, 0, 8'h00, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("post_reset_idle", 0, 0, 0, 8'h00, 8'h00);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL irq_missing got left=%0d want left=0",
        exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Multi-source external interrupt controller that sits directly upstream of `cp0` and drives its `ir_in` input. Synchronises up to `N_SRC` asynchronous interrupt lines, latches them into a pending register, and gates them with a software-writable mask. It selects the highest-priority enabled request, pulses `ir_out` to `cp0`, and holds the claimed source ID stable until the handler's ERET acknowledges service.

## Interface
- `N_SRC`, default 8: number of interrupt sources, 2..32.
- `ID_W`, default 3: width of `cause_id`; must be ≥ clog2(`N_SRC`).

Ports:
- `clk` in 1: main clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high. One clock domain only.
- `irq_src` in `N_SRC`: raw asynchronous interrupt lines. Bit 0 has the highest priority.
- `mask_we` in 1: write enable for the mask register.
- `mask_wdata` in `N_SRC`: new mask value. 1 = source enabled.
- `ack` in 1: one-cycle pulse when the handler's ERET executes, taken from the same condition that raises `cp0` ERET jump.
- `ir_out` out 1: interrupt request to `cp0` `ir_in`, a registered one-cycle pulse.
- `cause_id` out `ID_W`: index of the claimed source, registered.
- `busy` out 1: high while a claimed interrupt is outstanding (state ≠ IDLE).
- `pending` out `N_SRC`: current pending register, readable by software.
- `mask` out `N_SRC`: current mask register.

## Operation
- **Synchroniser:** 2-flop synchroniser per source (`s1`, `s2`), plus a history flop `s3` for edge detection.
- **Pending bit set:** `pending[i]` is set at an edge where `s2[i] & ~s3[i]` (rising edge). The mask does not gate capture.
- **Selection:** `req = pending & mask`. The winner is the lowest set index of `req`.
- **FSM states:**
  - IDLE → REQ when `req ≠ 0`. At that edge: `cause_id` ← winner, `pending[winner]` cleared (claimed), `ir_out` ← 1.
  - REQ → SERVICE unconditionally after one cycle. `ir_out` ← 0.
  - SERVICE → IDLE on `ack`. `cause_id` holds its value.
- **`ack` handling:** `ack` is ignored in IDLE and REQ.
- **Simultaneous claim and set:** a new edge on the claimed source in the same cycle as its claim sets the pending bit again. The set wins over the claim-clear.
- **Mask write:** `mask_we` updates `mask` at the next edge. A masked pending bit is retained and becomes eligible once unmasked.
- **Masking during service:** masking the source being serviced does not abort the service.
- **Reset values:** `s1`, `s2`, `s3`, `pending` = 0; `mask` = 0 (all masked); state IDLE; `ir_out` = 0; `cause_id` = 0; `busy` = 0.
- **Reset mid-operation:** asserting `rst` at any point abandons service immediately, asynchronously.

## Timing
- **Capture latency:** `irq_src[i]` is first sampled high at edge E0. `s1` is set at E0, `s2` at E1, and `pending[i]` at E2.
- **Request latency:** if the source is enabled and the FSM is idle, the IDLE→REQ transition occurs at E3. `ir_out` is high for the cycle E3–E4. Total 4 edges.
- **Pulse width:** `ir_out` is never high for more than one consecutive cycle.
- **Minimum gap:** back-to-back interrupts need at least 3 cycles between `ir_out` pulses. The sequence is REQ, then SERVICE with `ack`, then IDLE→REQ at the next edge.
- **`busy`:** high from E3 to the edge at which `ack` is sampled in SERVICE.
- **Pulse width requirement:** a source pulse must be ≥ 2 `clk` periods wide to be captured in edge mode.

## Configuration
- **Macro:** `IRQ_LEVEL_EN`.
- **Defined:** sources are level-sensitive. `pending[i]` tracks `s2[i]` directly: set while high, cleared when low. There is no history flop.
  - Claim does not clear the pending bit. Software must deassert the line before ERET, otherwise the source re-requests on return to IDLE.
  - Capture latency becomes 2 edges (pending at E1) and request at E2.
- **Undefined (default):** rising-edge capture with sticky pending as above.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately, state IDLE.
- **Single source latency:** mask=8'hFF, raise `irq_src[5]` at E0 → `pending[5]`=1 after E2. `ir_out` is a 1-cycle pulse after E3, `cause_id`=5, `busy`=1. `ack` → `busy`=0, `pending`=0.
- **Priority:** raise `irq_src[6]` and `irq_src[2]` together with mask=8'hFF → `cause_id`=2. After `ack`, a second `ir_out` fires with `cause_id`=6.
- **Masking:** mask=8'h00, pulse `irq_src[3]` → `pending`=8'h08 and no `ir_out`. Write mask=8'h08 → `ir_out` 1 cycle after the mask takes effect, `cause_id`=3.
- **Ignored ack / re-trigger:** `ack` while in IDLE → no effect. Re-edge `irq_src[1]` during its SERVICE → `pending[1]`=1 and a new `ir_out` in the cycle after `ack`.
- **Level mode (`IRQ_LEVEL_EN`):** hold `irq_src[0]` high through `ack` → `ir_out` re-pulses. Drop it before `ack` → no re-request.
